// File: rtl/sipo_receiver_pkg.sv
// rtl/sipo_receiver_pkg.sv - shared state encoding and defaults for the SIPO receiver
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_receiver_if.sv
// rtl/sipo_receiver_if.sv - serial line and parallel word handshake bundle
interface sipo_receiver_if #(
    parameter int WIDTH = sipo_pkg::DEFAULT_WIDTH
);
    logic             sel;
    logic             Din;
    logic             Dout_ready;
    logic [WIDTH-1:0] Dout;
    logic             Dout_valid;
    logic             frame_err;
    logic             overrun;

    modport master (
        input  sel, Din, Dout_ready,
        output Dout, Dout_valid, frame_err, overrun
    );

    modport slave (
        output sel, Din, Dout_ready,
        input  Dout, Dout_valid, frame_err, overrun
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - serial-in shift register exposing the post-shift word
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q;

    // q_next lets the owner capture a word on the same edge that samples its last bit
    generate
        if (MSB_FIRST) begin : g_msb
            assign q_next = {q[WIDTH-2:0], din};
        end else begin : g_lsb
            assign q_next = {din, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_receiver.sv
// rtl/sipo_receiver.sv - framed serial-to-parallel receiver with valid/ready output buffer
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           Clk,
    input  logic           reset,
    sipo_receiver_if.master bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] word_next;
    logic             shift_en;
    logic             abort;
    logic             complete;
    logic             accept;

    assign shift_en = ~bus.sel;
    assign abort    = (state == SHIFT) && bus.sel;
    assign complete = (state == SHIFT) && ~bus.sel && (count == LAST);
    assign accept   = bus.Dout_valid && bus.Dout_ready;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk    (Clk),
        .clr    (reset || abort),
        .en     (shift_en),
        .din    (bus.Din),
        .q_next (word_next)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            bus.Dout       <= '0;
            bus.Dout_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.sel) begin
                        count <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.sel) begin
                        count         <= '0;
                        state         <= IDLE;
                        bus.frame_err <= 1'b1;
                    end else if (count == LAST) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase

            // A word finishing while the buffer is held is dropped, not queued
            if (complete) begin
                if (!bus.Dout_valid || bus.Dout_ready) begin
                    bus.Dout       <= word_next;
                    bus.Dout_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (accept) begin
                bus.Dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = first serial bit lands in Dout[WIDTH-1], 0 = first bit lands in Dout[0].
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sel  input  1  framing; 0 = serial bit present on Din this cycle (shift phase), 1 = line idle/load phase.
REQ-006 Port: Din  input  1  serial data bit, sampled only when sel=0.
REQ-007 Port: Dout_ready  input  1  consumer accepts Dout on any rising edge where Dout_valid=1 and Dout_ready=1.
REQ-008 Port: Dout  output  WIDTH  last completed parallel word.
REQ-009 Port: Dout_valid  output  1  Dout holds an unconsumed word.
REQ-010 Port: frame_err  output  1  one-cycle pulse; partial word discarded.
REQ-011 Port: overrun  output  1  sticky; a completed word was dropped.

Function
REQ-012 FSM states: IDLE (bit count 0), SHIFT (bit count 1..WIDTH-1).
REQ-013 IDLE, sel=0: sample Din into shift register, count=1, go SHIFT; sel=1: stay IDLE.
REQ-014 SHIFT, sel=0, count<WIDTH-1: sample Din, count+1.
REQ-015 SHIFT, sel=0, count=WIDTH-1: sample final bit, count=0, go IDLE, word complete on this edge.
REQ-016 SHIFT, sel=1: discard partial word, count=0, go IDLE, frame_err=1 for exactly the next cycle.
REQ-017 Latency: completed word appears on Dout with Dout_valid=1 in the cycle immediately after the edge sampling its last bit.
REQ-018 Back-to-back words need no idle gap: sel may stay 0 across word boundaries.
REQ-019 Dout and Dout_valid hold stable while Dout_valid=1 and Dout_ready=0.
REQ-020 Accept edge with no completion: Dout_valid clears; Dout keeps its value.
REQ-021 Completion with Dout_valid=0: load Dout, set Dout_valid.
REQ-022 Completion coincident with accept: load new word, Dout_valid stays 1; no overrun.
REQ-023 Completion while Dout_valid=1 and Dout_ready=0: new word dropped, Dout unchanged, overrun set and held until reset.
REQ-024 Dout_ready while Dout_valid=0 has no effect.

Reset
REQ-025 reset=1 on a rising edge: state=IDLE, count=0, shift register=0, Dout=0, Dout_valid=0, frame_err=0, overrun=0.
REQ-026 Reset overrides all other inputs, including mid-word and mid-handshake; partial word discarded without frame_err.
REQ-027 First bit may be sampled on the first edge with reset=0.

Structure
REQ-028 Package sipo_pkg holds the FSM state encoding (IDLE, SHIFT) and default WIDTH constant.
REQ-029 Counter width is $clog2(WIDTH), derived from WIDTH.
REQ-030 One sub-module, sipo_shift_reg (WIDTH, MSB_FIRST, shift enable, clear); FSM, output buffer and flags stay in sipo_receiver.

Verification
REQ-031 Reset, sel=0 for 4 cycles with Din=1,0,0,1, Dout_ready=1 -> Dout=4'b1001, Dout_valid=1 for one cycle, then 0.
REQ-032 sel=0 for 8 cycles, Din=1,0,0,1,1,1,1,1, Dout_ready=1 -> 4'b1001 then 4'b1111 on consecutive word boundaries, no gap, overrun=0.
REQ-033 Same 8-bit stream with Dout_ready=0 -> Dout stays 4'b1001, Dout_valid=1, overrun=1 after 8th edge and held.
REQ-034 sel=0 for 2 bits then sel=1 -> frame_err one-cycle pulse, Dout_valid=0; following stream 1,0,1,1 -> Dout=4'b1011.
REQ-035 Reset asserted after 2 bits of a word -> all outputs 0 next cycle; next 4-bit stream 1,1,1,1 -> Dout=4'b1111.
REQ-036 Dout_ready raised on the edge completing a second word -> Dout updates to the second word, Dout_valid stays 1, overrun=0.
